uart_send_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO. It is the successor to the single-byte `send` block. Generalisations over `send`:
- configurable data width, bit time, parity mode and stop-bit count;
- a DEPTH-entry buffer behind a valid/ready write port.

It sits between the CPU/chipset output path and the board UART_TX pin, and streams queued words back-to-back with no idle gap between frames.

---
 rtl/uart_send_fifo_pkg.sv | 22 ++
 rtl/uart_send_fifo_sync_fifo.sv | 48 ++++
 rtl/uart_send_fifo.sv | 172 +++++++++++++++++
 tb/tb_uart_send_fifo.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_send_fifo_pkg.sv
// Shared types for the buffered UART transmitter.
// Holds the frame FSM state encoding and the parity mode codes.
package uart_send_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } UART_STATE_TYPE;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Parity bit for a data word under the given mode.
   function automatic logic parity_bit(input logic x, input int mode);
      return x ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_send_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: CLOCK, RESET (sync, active-high), push/din in, pop in, dout = head word,
// level = occupancy 0..DEPTH.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (push)
         mem[wptr] <= din;
   end

   assign dout = mem[rptr];

endmodule

// File: rtl/uart_send_fifo.sv
// UART transmitter with a DEPTH-entry write buffer; frames stream back-to-back.
// Ports: CLOCK, RESET (sync, active-high), wr_data/wr_valid/wr_ready write port,
// UART_TX registered serial line (idle high), busy, level (FIFO occupancy).
module uart_send_fifo
   import uart_send_fifo_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int WTIME     = 10,
   parameter int DEPTH     = 4,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic                     UART_TX,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(WTIME);
   localparam int CW = $clog2(DATA_W);

   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_send_fifo: DATA_W must be 5..9");
   end
   if (WTIME < 2) begin : g_bad_wtime
      $error("uart_send_fifo: WTIME must be >= 2");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_send_fifo: DEPTH must be a power of two >= 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_send_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_send_fifo: STOP_BITS must be 1 or 2");
   end

   UART_STATE_TYPE    state, state_n;
   logic [TW-1:0]     timer, timer_n;
   logic [CW-1:0]     bitcnt, bitcnt_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par, par_n;
   logic              tx, tx_n;
   logic              push, pop, load, last, has_data;
   logic [DATA_W-1:0] dout;

   assign has_data = (level != '0);
   assign wr_ready = (level != LW'(DEPTH));
   assign push     = wr_valid && wr_ready;
   assign last     = (timer == TW'(WTIME - 1));
   assign busy     = (state != IDLE) || has_data;
   assign UART_TX  = tx;
   assign pop      = load;

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .push  (push),
      .pop   (pop),
      .din   (wr_data),
      .dout  (dout),
      .level (level)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state  <= IDLE;
         timer  <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         par    <= 1'b0;
         tx     <= 1'b1;
      end else begin
         state  <= state_n;
         timer  <= timer_n;
         bitcnt <= bitcnt_n;
         shreg  <= shreg_n;
         par    <= par_n;
         tx     <= tx_n;
      end
   end

   always_comb begin
      state_n  = state;
      timer_n  = timer;
      bitcnt_n = bitcnt;
      shreg_n  = shreg;
      par_n    = par;
      tx_n     = tx;
      load     = 1'b0;

      if (state != IDLE)
         timer_n = last ? '0 : timer + 1'b1;

      unique case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (has_data)
               load = 1'b1;
         end
         START: begin
            if (last) begin
               state_n  = DATA;
               tx_n     = shreg[0];
               bitcnt_n = '0;
            end
         end
         DATA: begin
            if (last) begin
               if (bitcnt == CW'(DATA_W - 1)) begin
                  if (PARITY != PARITY_NONE) begin
                     state_n = PAR;
                     tx_n    = par;
                  end else begin
                     state_n  = STOP;
                     tx_n     = 1'b1;
                     bitcnt_n = '0;
                  end
               end else begin
                  // The shifter keeps the current bit at [0]; the next one is [1].
                  bitcnt_n = bitcnt + 1'b1;
                  shreg_n  = shreg >> 1;
                  tx_n     = shreg[1];
               end
            end
         end
         PAR: begin
            if (last) begin
               state_n  = STOP;
               tx_n     = 1'b1;
               bitcnt_n = '0;
            end
         end
         STOP: begin
            if (last) begin
               if (bitcnt == CW'(STOP_BITS - 1)) begin
                  // Chain straight into the next start bit when work is queued.
                  if (has_data) begin
                     load = 1'b1;
                  end else begin
                     state_n = IDLE;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bitcnt_n = bitcnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase

      if (load) begin
         state_n = START;
         timer_n = '0;
         shreg_n = dout;
         par_n   = parity_bit(^dout, PARITY);
         tx_n    = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_send_fifo.sv
// Self-checking bench for uart_send_fifo: four parameter variants,
// a queue-level frame model checked every cycle, plus literal pins.
module tb_uart_send_fifo;

   localparam int NI = 4;
   localparam int DW = 8;
   localparam int WT = 10;
   localparam int DP = 4;
   localparam int LG = 8192;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        wr_data = '0;
   logic [NI-1:0]     wr_valid = '0;
   logic [NI-1:0]     wr_ready;
   logic [NI-1:0]     tx;
   logic [NI-1:0]     busy;
   logic [NI-1:0][2:0] level;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // 0: plain, 1: even parity, 2: odd parity, 3: two stop bits
   for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_send_fifo #(
         .DATA_W    (DW),
         .WTIME     (WT),
         .DEPTH     (DP),
         .PARITY    (g == 1 ? 1 : (g == 2 ? 2 : 0)),
         .STOP_BITS (g == 3 ? 2 : 1)
      ) u (
         .CLOCK    (clk),
         .RESET    (rst),
         .wr_data  (wr_data),
         .wr_valid (wr_valid[g]),
         .wr_ready (wr_ready[g]),
         .UART_TX  (tx[g]),
         .busy     (busy[g]),
         .level    (level[g])
      );
   end

   function automatic int par_of(int g);
      return g == 1 ? 1 : (g == 2 ? 2 : 0);
   endfunction

   function automatic int sb_of(int g);
      return g == 3 ? 2 : 1;
   endfunction

   function automatic int flen(int g);
      return WT * (1 + DW + (par_of(g) != 0 ? 1 : 0) + sb_of(g));
   endfunction

   // Line level at cycle p of a frame carrying w.
   function automatic logic fbit(int g, logic [7:0] w, int p);
      int s;
      s = p / WT;
      if (s == 0) return 1'b0;
      if (s <= DW) return w[s-1];
      if (par_of(g) != 0 && s == DW + 1)
         return (^w) ^ (par_of(g) == 2);
      return 1'b1;
   endfunction

   logic [7:0] mq [NI][8];
   int         mh [NI];
   int         mn [NI];
   bit         inf [NI];
   int         pos [NI];
   logic [7:0] fw [NI];

   task automatic step();
      for (int g = 0; g < NI; g++) begin
         int pn;
         bit acc;
         pn = mn[g];
         if (rst) begin
            mn[g] = 0;
            mh[g] = 0;
            inf[g] = 0;
            pos[g] = 0;
         end else begin
            acc = wr_valid[g] && (pn != DP);
            if (inf[g]) begin
               pos[g]++;
               if (pos[g] == flen(g)) inf[g] = 0;
            end
            if (!inf[g] && pn > 0) begin
               fw[g] = mq[g][mh[g]];
               mh[g] = (mh[g] + 1) % 8;
               mn[g]--;
               inf[g] = 1;
               pos[g] = 0;
            end
            if (acc) begin
               mq[g][(mh[g] + mn[g]) % 8] = wr_data;
               mn[g]++;
            end
         end
      end
   endtask

   task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h",
                  nm, g, cyc, act, exp);
      end
   endtask

   logic [NI-1:0] txlog  [LG];
   logic [NI-1:0] bsylog [LG];
   logic [NI-1:0] rdylog [LG];
   logic [2:0]    lvl0   [LG];

   initial forever begin
      @(posedge clk);
      step();
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (cyc < LG) begin
         txlog[cyc]  = tx;
         bsylog[cyc] = busy;
         rdylog[cyc] = wr_ready;
         lvl0[cyc]   = level[0];
      end
      if (cyc > 0) begin
         for (int g = 0; g < NI; g++) begin
            chk("tx", g, 32'(tx[g]),
                32'(inf[g] ? fbit(g, fw[g], pos[g]) : 1'b1));
            chk("busy", g, 32'(busy[g]), 32'(inf[g] || mn[g] != 0));
            chk("level", g, 32'(level[g]), 32'(mn[g]));
            chk("wr_ready", g, 32'(wr_ready[g]), 32'(mn[g] != DP));
         end
      end
   end

   // Presents d on port g and returns the edge index at which it is taken.
   task automatic put(int g, logic [7:0] d, output int acc);
      wr_data = d;
      wr_valid[g] = 1'b1;
      acc = -1;
      for (int i = 0; i < 2000; i++) begin
         if (wr_ready[g]) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL put_timeout[%0d] cyc %0d: got no ready expected ready", g, cyc);
         acc = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      wr_valid = '0;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 3000; i++) begin
         if (busy == '0) break;
         @(negedge clk);
      end
      if (i == 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout cyc %0d: got busy %0h expected 0", cyc, busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic frame_pins(string nm, int g, int s, logic [9:0] f);
      for (int b = 0; b < 10; b++)
         chk(nm, g, 32'(txlog[s + b*WT + 5][g]), 32'(f[b]));
   endtask

   initial begin
      int a, a1, s, hi;
      int acc [7];
      logic [7:0] words [7];
      words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

      repeat (2) @(negedge clk);
      chk("rst_tx", 0, 32'(tx[0]), 32'd1);
      chk("rst_busy", 0, 32'(busy[0]), 32'd0);
      chk("rst_level", 0, 32'(level[0]), 32'd0);
      chk("rst_ready", 0, 32'(wr_ready[0]), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // single word
      put(0, 8'b01100111, a);
      idle();
      wait_idle();
      s = a + 1;
      chk("t1_pre", 0, 32'(txlog[a][0]), 32'd1);
      frame_pins("t1_slot", 0, s, 10'b1_01100111_0);
      chk("t1_busy_end", 0, 32'(bsylog[s + 99][0]), 32'd1);
      chk("t1_busy_off", 0, 32'(bsylog[s + 100][0]), 32'd0);

      // parity
      put(1, 8'h07, a);
      idle();
      wait_idle();
      chk("t2_even07", 1, 32'(txlog[a + 1 + 95][1]), 32'd1);
      chk("t2_len_on", 1, 32'(bsylog[a + 1 + 109][1]), 32'd1);
      chk("t2_len_off", 1, 32'(bsylog[a + 1 + 110][1]), 32'd0);
      put(2, 8'h07, a);
      idle();
      wait_idle();
      chk("t2_odd07", 2, 32'(txlog[a + 1 + 95][2]), 32'd0);
      chk("t2_len_off", 2, 32'(bsylog[a + 1 + 110][2]), 32'd0);
      put(1, 8'h03, a);
      idle();
      wait_idle();
      chk("t2_even03", 1, 32'(txlog[a + 1 + 95][1]), 32'd0);

      // back-to-back
      put(0, 8'hA5, a);
      put(0, 8'h3C, a1);
      idle();
      wait_idle();
      s = a + 1;
      chk("t3_consec", 0, 32'(a1 - a), 32'd1);
      chk("t3_stop", 0, 32'(txlog[s + 99][0]), 32'd1);
      chk("t3_start2", 0, 32'(txlog[s + 100][0]), 32'd0);
      frame_pins("t3_f2", 0, s + 100, 10'b1_00111100_0);
      chk("t3_busy_off", 0, 32'(bsylog[s + 200][0]), 32'd0);

      // overflow
      for (int k = 0; k < 7; k++)
         put(0, words[k], acc[k]);
      idle();
      wait_idle();
      chk("t4_five", 0, 32'(acc[4] - acc[0]), 32'd4);
      chk("t4_full", 0, 32'(lvl0[acc[4]]), 32'd4);
      chk("t4_noready", 0, 32'(rdylog[acc[4]][0]), 32'd0);
      chk("t4_sixth", 0, 32'(acc[5] - acc[0]), 32'd102);
      chk("t4_seventh", 0, 32'(acc[6] - acc[5]), 32'd100);
      frame_pins("t4_last", 0, acc[0] + 1 + 600, 10'b1_01110111_0);

      // two stop bits
      put(3, 8'hFF, a);
      idle();
      wait_idle();
      s = a + 1;
      hi = 0;
      for (int i = 90; i < 110; i++)
         hi += int'(txlog[s + i][3]);
      chk("t5_stop_hi", 3, 32'(hi), 32'd20);
      chk("t5_start", 3, 32'(txlog[s + 5][3]), 32'd0);
      chk("t5_len_on", 3, 32'(bsylog[s + 109][3]), 32'd1);
      chk("t5_len_off", 3, 32'(bsylog[s + 110][3]), 32'd0);

      // reset mid-frame
      put(0, 8'hA1, a);
      put(0, 8'hB2, a1);
      put(0, 8'hC3, a1);
      idle();
      s = a + 1;
      for (int i = 0; i < 200 && cyc < s + 43; i++)
         @(negedge clk);
      chk("t6_bit3", 0, 32'(tx[0]), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_tx", 0, 32'(tx[0]), 32'd1);
      chk("t6_level", 0, 32'(level[0]), 32'd0);
      chk("t6_busy", 0, 32'(busy[0]), 32'd0);
      repeat (15) @(negedge clk);
      chk("t6_quiet", 0, 32'(tx[0]), 32'd1);
      put(0, 8'h55, a);
      idle();
      wait_idle();
      frame_pins("t6_clean", 0, a + 1, 10'b1_01010101_0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc %0d: got no finish expected finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
